// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Holds the response-owner encoding and the default bus widths used by
// the arbiter interface.
package mips_mem_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_IF   = 2'd1;
  localparam owner_t OWN_DM   = 2'd2;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter. It carries the instruction-fetch port (if_*),
// the data load/store port (dm_*) and the unified memory port (mem_*).
//   slave  : arbiter view. Takes the requests and mem_rdata, and drives the
//            grants, the responses and the memory command.
//   master : core/memory view. This is the mirror image of slave.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter that counts consecutive cycles in which a requester
// is refused.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   inc        : count one more refused cycle (holds once saturated)
//   clr        : return to zero (takes priority over inc)
//   sat        : the count has reached MAX
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && cnt != MAX_V)
      cnt <= cnt + W'(1);
  end

  assign sat = (cnt == MAX_V);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch (IF)
// and data load/store (DM). The data port normally has priority. After
// MAX_WAIT consecutive refused IF cycles, IF is forced through. Read data
// comes back one cycle after the grant and goes to the port that owns it.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   bus        : IF, DM and memory signals (slave modport)
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);
  logic   force_if;
  logic   if_gnt;
  logic   dm_gnt;
  logic   starve_inc;
  logic   starve_clr;
  owner_t resp_own;
  owner_t own_nxt;

  assign starve_inc = bus.if_req & ~if_gnt;
  assign starve_clr = if_gnt | ~bus.if_req;

  starve_counter #(.MAX(MAX_WAIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (force_if)
  );

  // Both grants are held low during reset so that no store can reach the memory.
  always_comb begin
    if_gnt = ~reset & bus.if_req & (~bus.dm_req | force_if);
    dm_gnt = ~reset & bus.dm_req & ~if_gnt;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (if_gnt) begin
      bus.mem_addr = bus.if_addr;
    end else if (dm_gnt) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_we    = bus.dm_we;
      bus.mem_wdata = bus.dm_wdata;
    end
  end

  // A store produces no response, so only loads claim the next read slot.
  always_comb begin
    own_nxt = OWN_NONE;
    if (if_gnt)
      own_nxt = OWN_IF;
    else if (dm_gnt && !bus.dm_we)
      own_nxt = OWN_DM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      resp_own <= OWN_NONE;
    else
      resp_own <= own_nxt;
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = (resp_own == OWN_IF);
  assign bus.dm_rvalid = (resp_own == OWN_DM);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
endmodule
